// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-bank write port: FSM encoding,
// requester identifiers and default bank geometry.
package regfile_write_arbiter_pkg;

    // Write-port sequencer states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Requester identifiers, also the encoding of last_grant
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Default bank geometry
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic. It is purely combinational, so it can be
// reused on any shared port that keeps its own record of the last winner.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic en,          // arbitration allowed this cycle
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,  // REQ_A or REQ_B, winner of the previous grant
    output logic grant_a,
    output logic grant_b
);

    // A contested cycle goes to whichever side did not win last time
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                if (last_grant == REQ_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register bank's single write port between the ALU writeback (A)
// and the load unit (B). A one-cycle bank clear runs after reset or on
// request; otherwise writes are arbitrated round-robin and presented to the
// bank as a registered one-hot enable plus data.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [NREGS-1:0]  rf_en,
    output logic              rf_clr,
    output logic [DATA_W-1:0] rf_d,
    output logic              busy,
    output logic              last_grant
);

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic [NREGS-1:0]  rf_en_reg, rf_en_next;
    logic              rf_clr_reg, rf_clr_next;
    logic [DATA_W-1:0] rf_d_reg, rf_d_next;
    logic              busy_reg, busy_next;

    logic              arb_en;
    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREGS-1:0]  wr_dec;

    // A pending clear request pre-empts any write in the same cycle
    assign arb_en = (state_reg == ST_RUN) && !clear_req;

    rr_arbiter2 u_arb (
        .en         (arb_en),
        .req_a      (a_valid),
        .req_b      (b_valid),
        .last_grant (last_grant_reg),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign wr_addr = grant_b ? b_addr : a_addr;
    assign wr_data = grant_b ? b_data : a_data;

    // Address to one-hot enable; register 0 is hard-wired when R0_ZERO is set,
    // so its handshake completes but the bank never sees an enable
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            if (R0_ZERO && (gi == 0)) begin : g_r0
                assign wr_dec[gi] = 1'b0;
            end else begin : g_reg
                assign wr_dec[gi] = (wr_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    // Next-state and next-output logic for the clear/run sequencer
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        rf_en_next      = '0;
        rf_clr_next     = 1'b0;
        rf_d_next       = rf_d_reg;
        busy_next       = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                state_next  = ST_RUN;
                rf_en_next  = '1;
                rf_clr_next = 1'b1;
                rf_d_next   = '0;
                busy_next   = 1'b1;
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_next = ST_CLEAR;
                    busy_next  = 1'b1;
                end else if (grant_a || grant_b) begin
                    last_grant_next = grant_b ? REQ_B : REQ_A;
                    rf_en_next      = wr_dec;
                    rf_d_next       = wr_data;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                busy_next  = 1'b1;
            end
        endcase
    end

    // State and registered bank-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_CLEAR;
            last_grant_reg <= REQ_B;
            rf_en_reg      <= '0;
            rf_clr_reg     <= 1'b0;
            rf_d_reg       <= '0;
            busy_reg       <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            rf_en_reg      <= rf_en_next;
            rf_clr_reg     <= rf_clr_next;
            rf_d_reg       <= rf_d_next;
            busy_reg       <= busy_next;
        end
    end

    assign rf_en      = rf_en_reg;
    assign rf_clr     = rf_clr_reg;
    assign rf_d       = rf_d_reg;
    assign busy       = busy_reg;
    assign last_grant = last_grant_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, with a reference model predicting grants, bank-port activity and
// bank contents, and a monitor comparing the DUT against it every cycle.
module tb_regfile_write_arbiter;

    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear_req = 1'b0;
    logic              a_valid = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic [NREGS-1:0]  rf_en;
    logic              rf_clr;
    logic [DATA_W-1:0] rf_d;
    logic              busy;
    logic              last_grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .R0_ZERO(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_en(rf_en), .rf_clr(rf_clr), .rf_d(rf_d),
        .busy(busy), .last_grant(last_grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The register bank, driven only by the DUT's bank-side outputs
    logic [DATA_W-1:0] bank [NREGS];
    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rf_en[i]) bank[i] <= rf_clr ? '0 : rf_d;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              clr;
        logic [NREGS-1:0]  en;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t sbq[$];

    bit                m_run  = 1'b0;   // model is past its clear and arbitrating
    bit                m_last = 1'b1;   // 1 = B won last, so A wins the next contest
    logic [DATA_W-1:0] m_bank [NREGS];
    bit                pend_v = 1'b0;   // bank effect due on the next edge
    bit                pend_clr = 1'b0;
    int                pend_addr = 0;
    logic [DATA_W-1:0] pend_data = '0;

    always @(posedge clk or posedge reset) begin
        int win;
        int addr;
        logic [DATA_W-1:0] data;
        if (reset) begin
            m_run  = 1'b0;
            m_last = 1'b1;
            pend_v = 1'b0;
            sbq.delete();
        end else begin
            if (pend_v) begin
                if (pend_clr) begin
                    for (int i = 0; i < NREGS; i++) m_bank[i] = '0;
                end else begin
                    m_bank[pend_addr] = pend_data;
                end
                pend_v = 1'b0;
            end
            if (!m_run) begin
                m_run = 1'b1;
                pend_v = 1'b1;
                pend_clr = 1'b1;
                sbq.push_back({1'b1, {NREGS{1'b1}}, {DATA_W{1'b0}}});
            end else if (clear_req) begin
                m_run = 1'b0;
            end else begin
                win = -1;
                if (a_valid && b_valid) win = m_last ? 0 : 1;
                else if (a_valid)       win = 0;
                else if (b_valid)       win = 1;
                if (win >= 0) begin
                    m_last = (win == 1);
                    addr = (win == 1) ? int'(b_addr) : int'(a_addr);
                    data = (win == 1) ? b_data : a_data;
                    if (addr != 0) begin
                        pend_v = 1'b1;
                        pend_clr = 1'b0;
                        pend_addr = addr;
                        pend_data = data;
                        sbq.push_back({1'b0, NREGS'(1) << addr, data});
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        bit ea, eb, ebusy;
        exp_t e;
        ea = 1'b0;
        eb = 1'b0;
        if (m_run && !reset && !clear_req) begin
            if (a_valid && b_valid) begin
                ea = m_last;
                eb = !m_last;
            end else begin
                ea = a_valid;
                eb = b_valid;
            end
        end
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        check("last_grant", last_grant, m_last);
        ebusy = !m_run || (sbq.size() > 0 && sbq[0].clr);
        check("busy", busy, ebusy);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rf_en", rf_en, e.en);
            check("rf_clr", rf_clr, e.clr);
            if (!e.clr) check("rf_d", rf_d, e.d);
        end else begin
            check("idle_rf_en", rf_en, 0);
            check("idle_rf_clr", rf_clr, 0);
        end
    end

    // ---------------- stimulus ----------------
    bit ga, gb;

    task automatic step();
        @(negedge clk);
        ga = a_valid && a_ready;
        gb = b_valid && b_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input bit want_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = want_b ? gb : ga;
        end
        check("grant_timeout", ok, 1);
    endtask

    task automatic compare_bank();
        for (int i = 0; i < NREGS; i++) check($sformatf("bank_r%0d", i), bank[i], m_bank[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit first_b;
        bit first_set;

        // Reset release and the clear cycle that follows
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1);
        check("reset_rf_en", rf_en, 0);
        reset = 1'b0;
        step();
        check("clear_rf_en", rf_en, 8'hFF);
        check("clear_rf_clr", rf_clr, 1);
        check("clear_busy", busy, 1);
        step();
        check("post_clear_busy", busy, 0);
        check("post_clear_rf_en", rf_en, 0);

        // Single write from A
        a_valid = 1'b1; a_addr = 3'd5; a_data = 16'hBEEF;
        wait_grant(1'b0, ok);
        a_valid = 1'b0;
        check("single_rf_en", rf_en, 8'h20);
        check("single_rf_d", rf_d, 16'hBEEF);
        step();
        check("single_bank_r5", bank[5], 16'hBEEF);

        // Write to register 0 is acknowledged but discarded
        b_valid = 1'b1; b_addr = 3'd0; b_data = 16'hFFFF;
        wait_grant(1'b1, ok);
        b_valid = 1'b0;
        check("r0_last_grant", last_grant, 1);
        check("r0_rf_en", rf_en, 0);
        step();
        check("r0_bank", bank[0], 0);

        // Contest: A wins first, B next cycle
        a_valid = 1'b1; a_addr = 3'd2; a_data = 16'h1111;
        b_valid = 1'b1; b_addr = 3'd3; b_data = 16'h2222;
        first_set = 1'b0;
        first_b = 1'b0;
        for (int i = 0; i < 10 && (a_valid || b_valid); i++) begin
            step();
            if ((ga || gb) && !first_set) begin
                first_set = 1'b1;
                first_b = gb;
            end
            if (ga) begin check("contest_en_a", rf_en, 8'h04); a_valid = 1'b0; end
            if (gb) begin check("contest_en_b", rf_en, 8'h08); b_valid = 1'b0; end
        end
        check("contest_first_is_b", first_b, 0);
        check("contest_done", a_valid || b_valid, 0);
        check("contest_last_grant", last_grant, 1);
        step();
        compare_bank();

        // Clear request wins over a simultaneous write
        clear_req = 1'b1;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 16'h1234;
        step();
        check("clr_vs_write_a_ready", ga, 0);
        clear_req = 1'b0;
        step();
        check("clr_state_a_ready", ga, 0);
        check("clr2_rf_en", rf_en, 8'hFF);
        check("clr2_rf_clr", rf_clr, 1);
        step();
        check("after_clr_accept", ga, 1);
        a_valid = 1'b0;
        step();
        check("after_clr_bank_r1", bank[1], 16'h1234);

        // Asynchronous reset between accept and the bank write
        a_valid = 1'b1; a_addr = 3'd6; a_data = 16'hCAFE;
        wait_grant(1'b0, ok);
        a_valid = 1'b0;
        check("mid_rf_en_before", rf_en, 8'h40);
        #2 reset = 1'b1;
        #1;
        check("mid_rf_en_reset", rf_en, 0);
        check("mid_busy_reset", busy, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        check("lost_write_r6", bank[6], 0);
        step();
        check("mid_clear_rf_en", rf_en, 8'hFF);
        check("mid_clear_rf_clr", rf_clr, 1);
        step();
        compare_bank();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_valid = 1'b1; a_addr = ADDR_W'($urandom); a_data = DATA_W'($urandom);
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_valid = 1'b1; b_addr = ADDR_W'($urandom); b_data = DATA_W'($urandom);
            end
            clear_req = ($urandom_range(0, 40) == 0);
            step();
            if (ga) a_valid = 1'b0;
            if (gb) b_valid = 1'b0;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        clear_req = 1'b0;
        repeat (4) step();
        compare_bank();
        check("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
